// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward Ethernet receive filter: buffers each frame, checks the destination
// address and the MAC's CRC verdict, then commits and replays the frame or rewinds it.
module eth_rx_frame_filter #(
  parameter int          DEPTH       = 4096,
  parameter logic [47:0] MAC_ADDR    = 48'h000A35000001,
  parameter bit          PROMISC     = 1'b0,
  parameter int          CRC_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  output logic        S_AXIS_TREADY,
  input  logic        CRC_GOOD,
  input  logic        CRC_BAD,
  output logic [7:0]  M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic [15:0] FRAME_OK_CNT,
  output logic [15:0] FRAME_DROP_CNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(CRC_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RECV, WAIT_CRC, DISCARD} state_t;

  state_t        st, st_n;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wp, wp_n, cwp, cwp_n, rp, base, nb;
  logic [2:0]    cnt, cnt_n, idx;
  logic          uc, bc, uc_n, bc_n, fu, fb;
  logic [TW-1:0] wcnt, wcnt_n;
  logic [15:0]   ok_cnt, drop_cnt;
  logic          ok_inc;
  logic [1:0]    drop_inc;
  logic          tready, beat, good, start, cont, we;
  logic [7:0]    mac_b;
  logic [8:0]    rdata, q0, q1;
  logic [1:0]    sk_cnt;
  logic          rd, rd_v, pop;

  function automatic logic [7:0] mac_byte(input logic [2:0] i);
    logic [47:0] s;
    s = MAC_ADDR << {i, 3'b000};
    return s[47:40];
  endfunction

  assign S_AXIS_TREADY  = tready;
  assign beat           = S_AXIS_TVALID && tready;
  assign good           = CRC_GOOD && !CRC_BAD;
  assign FRAME_OK_CNT   = ok_cnt;
  assign FRAME_DROP_CNT = drop_cnt;

  always_comb begin
    st_n = st; wp_n = wp; cwp_n = cwp; cnt_n = cnt; uc_n = uc; bc_n = bc;
    wcnt_n = wcnt; ok_inc = 1'b0; drop_inc = 2'd0; we = 1'b0;
    start = 1'b0; cont = 1'b0; base = wp; nb = wp + 1'b1; idx = cnt;
    mac_b = 8'h00; fu = uc; fb = bc;
    unique case (st)
      IDLE: start = beat;
      RECV: cont = beat;
      WAIT_CRC: begin
        wcnt_n = wcnt + 1'b1;
        if (good) begin
          cwp_n = wp; ok_inc = 1'b1; st_n = IDLE;
        end else if (CRC_BAD || beat || wcnt == TW'(CRC_TIMEOUT - 1)) begin
          wp_n = cwp; drop_inc = 2'd1; st_n = IDLE;
        end
        // a new beat always resolves the pending frame first, then starts over at cwp_n
        start = beat;
      end
      DISCARD: if (beat && S_AXIS_TLAST) begin
        wp_n = cwp; drop_inc = 2'd1; st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
    if (start || cont) begin
      idx  = start ? 3'd0 : cnt;
      base = start ? cwp_n : wp;
      nb   = base + 1'b1;
      if (nb == rp) begin
        wp_n = cwp_n;
        if (S_AXIS_TLAST) begin drop_inc = drop_inc + 2'd1; st_n = IDLE; end
        else st_n = DISCARD;
      end else begin
        we    = 1'b1;
        wp_n  = nb;
        mac_b = mac_byte(idx);
        if (idx < 3'd6) begin
          fu = (start || uc) && (S_AXIS_TDATA == mac_b);
          fb = (start || bc) && (S_AXIS_TDATA == 8'hFF);
        end
        uc_n  = fu;
        bc_n  = fb;
        cnt_n = (idx == 3'd7) ? 3'd7 : idx + 3'd1;
        if (S_AXIS_TLAST) begin
          if (idx < 3'd5 || (!fu && !fb && !PROMISC)) begin
            wp_n = cwp_n; drop_inc = drop_inc + 2'd1; st_n = IDLE;
          end else if (good) begin
            cwp_n = nb; ok_inc = 1'b1; st_n = IDLE;
          end else if (CRC_BAD) begin
            wp_n = cwp_n; drop_inc = drop_inc + 2'd1; st_n = IDLE;
          end else begin
            st_n = WAIT_CRC; wcnt_n = '0;
          end
        end else begin
          st_n = RECV;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (we) mem[base] <= {S_AXIS_TLAST, S_AXIS_TDATA};
    if (rd) rdata <= mem[rp];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st <= IDLE; wp <= '0; cwp <= '0; cnt <= '0; uc <= 1'b0; bc <= 1'b0;
      wcnt <= '0; ok_cnt <= '0; drop_cnt <= '0; tready <= 1'b0;
    end else begin
      st <= st_n; wp <= wp_n; cwp <= cwp_n; cnt <= cnt_n; uc <= uc_n; bc <= bc_n;
      wcnt <= wcnt_n; tready <= 1'b1;
      ok_cnt   <= ok_cnt + 16'(ok_inc);
      drop_cnt <= drop_cnt + 16'(drop_inc);
    end
  end

  // Skid plus the in-flight RAM read never exceed two entries, so a read is issued
  // only when a slot is guaranteed by the time its data lands.
  assign pop = (sk_cnt != 2'd0) && M_AXIS_TREADY;
  assign rd  = (rp != cwp) && ((sk_cnt + {1'b0, rd_v} - {1'b0, pop}) < 2'd2);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rp <= '0; rd_v <= 1'b0; sk_cnt <= 2'd0; q0 <= '0; q1 <= '0;
    end else begin
      rd_v <= rd;
      if (rd) rp <= rp + 1'b1;
      case ({pop, rd_v})
        2'b11: if (sk_cnt == 2'd2) begin q0 <= q1; q1 <= rdata; end
               else q0 <= rdata;
        2'b10: begin q0 <= q1; sk_cnt <= sk_cnt - 2'd1; end
        2'b01: begin
          if (sk_cnt == 2'd0) q0 <= rdata;
          else q1 <= rdata;
          sk_cnt <= sk_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign M_AXIS_TVALID = (sk_cnt != 2'd0);
  assign M_AXIS_TDATA  = q0[7:0];
  assign M_AXIS_TLAST  = q0[8];
endmodule
